// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command-driven up/down counter sequencer with pause/resume/abort
//
// Purpose: owns a WIDTH-bit counter. A START command loads a start value and
// runs the counter toward a programmed terminal value. At the terminal value the
// counter either reloads or stops. PAUSE, RESUME and ABORT commands control the
// run. Commands that do not apply in the current state are flagged with err.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous reset, active-high
//   cmd_valid   command present
//   cmd_ready   command can be accepted (combinational, !rst)
//   cmd_op      00 START, 01 PAUSE, 10 RESUME, 11 ABORT
//   cfg_init    start/reload value, latched on START
//   cfg_term    terminal value, latched on START
//   cfg_dir     1 = count up, 0 = count down, latched on START
//   cfg_reload  1 = auto-reload, 0 = one-shot, latched on START
//   q           current count (registered)
//   busy        sequencer not idle (registered)
//   tc          one-cycle pulse, terminal value reached
//   done        one-cycle pulse, one-shot run completed
//   err         one-cycle pulse, illegal command accepted
module counter_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_init,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_dir,
    input  logic             cfg_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] init_q;
    logic [WIDTH-1:0] term_q;
    logic             dir_q;
    logic             reload_q;
    logic             busy_q;
    logic             tc_q;
    logic             done_q;
    logic             err_q;

    // No back-pressure: the only time a command is refused is during reset.
    assign cmd_ready = !rst;

    assign q    = cnt_q;
    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            init_q   <= '0;
            term_q   <= '0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Pulses default low; they are set only on the edge of their event.
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (cmd_valid) begin
                // An accepted command takes the edge, so any count step due on this
                // edge is dropped together with its tc/done.
                case (cmd_op)
                    OP_START: begin
                        init_q   <= cfg_init;
                        term_q   <= cfg_term;
                        dir_q    <= cfg_dir;
                        reload_q <= cfg_reload;
                        cnt_q    <= cfg_init;
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                    end
                    OP_PAUSE: begin
                        if (state_q == ST_RUN) begin
                            state_q <= ST_PAUSED;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    OP_RESUME: begin
                        if (state_q == ST_PAUSED) begin
                            state_q <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin // OP_ABORT
                        if (state_q == ST_IDLE) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                endcase
            end else if (state_q == ST_RUN) begin
                // The terminal check is made on the value already shown on q, so
                // tc/done follow one cycle after q reaches the terminal value.
                if (cnt_q == term_q) begin
                    tc_q <= 1'b1;
                    if (reload_q) begin
                        cnt_q <= init_q;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end else if (dir_q) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - table-driven self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

    localparam int WIDTH = 3;

    localparam logic [1:0] START  = 2'b00;
    localparam logic [1:0] PAUSE  = 2'b01;
    localparam logic [1:0] RESUME = 2'b10;
    localparam logic [1:0] ABORT  = 2'b11;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cfg_init;
    logic [WIDTH-1:0] cfg_term;
    logic             cfg_dir;
    logic             cfg_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cfg_init   (cfg_init),
        .cfg_term   (cfg_term),
        .cfg_dir    (cfg_dir),
        .cfg_reload (cfg_reload),
        .q          (q),
        .busy       (busy),
        .tc         (tc),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             valid;
        logic [1:0]       op;
        logic [WIDTH-1:0] init;
        logic [WIDTH-1:0] term;
        logic             dir;
        logic             reload;
        logic [WIDTH-1:0] exp_q;
        logic             exp_busy;
        logic             exp_tc;
        logic             exp_done;
        logic             exp_err;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [WIDTH-1:0] init, input logic [WIDTH-1:0] term,
                                input logic dir, input logic reload,
                                input logic [WIDTH-1:0] eq, input logic eb,
                                input logic et, input logic ed, input logic ee);
        vec_t t;
        t.rst = r; t.valid = v; t.op = op; t.init = init; t.term = term;
        t.dir = dir; t.reload = reload; t.exp_q = eq; t.exp_busy = eb;
        t.exp_tc = et; t.exp_done = ed; t.exp_err = ee;
        return t;
    endfunction

    function automatic vec_t idle(input logic [WIDTH-1:0] eq, input logic eb,
                                  input logic et, input logic ed);
        return mk(1'b0, 1'b0, START, 3'd0, 3'd0, 1'b0, 1'b0, eq, eb, et, ed, 1'b0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] init, input logic [WIDTH-1:0] term,
                         input logic dir, input logic reload);
        rst = r; cmd_valid = v; cmd_op = op; cfg_init = init; cfg_term = term;
        cfg_dir = dir; cfg_reload = reload;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int eq, input int eb,
                              input int et, input int ed, input int ee);
        chk({tag, ".q"},    int'(q),    eq);
        chk({tag, ".busy"}, int'(busy), eb);
        chk({tag, ".tc"},   int'(tc),   et);
        chk({tag, ".done"}, int'(done), ed);
        chk({tag, ".err"},  int'(err),  ee);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] init,
                       input logic [WIDTH-1:0] term, input logic dir, input logic reload);
        drive(1'b0, 1'b1, op, init, term, dir, reload);
        tick();
    endtask

    task automatic nop;
        drive(1'b0, 1'b0, START, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // Reset, one-shot up with wrap 5->2.
        vecs[0]  = mk(1, 0, START, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, START, 5, 2, 1, 0,  5, 1, 0, 0, 0);
        vecs[2]  = idle(6, 1, 0, 0);
        vecs[3]  = idle(7, 1, 0, 0);
        vecs[4]  = idle(0, 1, 0, 0);
        vecs[5]  = idle(1, 1, 0, 0);
        vecs[6]  = idle(2, 1, 0, 0);
        vecs[7]  = idle(2, 0, 1, 1);
        vecs[8]  = idle(2, 0, 0, 0);
        // RESUME in IDLE is illegal.
        vecs[9]  = mk(0, 1, RESUME, 0, 0, 0, 0,  2, 0, 0, 0, 1);
        vecs[10] = idle(2, 0, 0, 0);
        // Auto-reload down 3->1.
        vecs[11] = mk(0, 1, START, 3, 1, 0, 1,  3, 1, 0, 0, 0);
        vecs[12] = idle(2, 1, 0, 0);
        vecs[13] = idle(1, 1, 0, 0);
        vecs[14] = idle(3, 1, 1, 0);
        vecs[15] = idle(2, 1, 0, 0);
        vecs[16] = idle(1, 1, 0, 0);
        vecs[17] = idle(3, 1, 1, 0);
        // ABORT from RUN, then illegal ABORT and PAUSE in IDLE.
        vecs[18] = mk(0, 1, ABORT, 0, 0, 0, 0,  3, 0, 0, 0, 0);
        vecs[19] = mk(0, 1, ABORT, 0, 0, 0, 0,  3, 0, 0, 0, 1);
        vecs[20] = mk(0, 1, PAUSE, 0, 0, 0, 0,  3, 0, 0, 0, 1);

        drive(1'b1, 1'b0, START, 3'd0, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].init,
                  vecs[i].term, vecs[i].dir, vecs[i].reload);
            #1;
            chk($sformatf("v%0d.cmd_ready", i), int'(cmd_ready), int'(!vecs[i].rst));
            tick();
            expect_out($sformatf("v%0d", i), int'(vecs[i].exp_q), int'(vecs[i].exp_busy),
                       int'(vecs[i].exp_tc), int'(vecs[i].exp_done), int'(vecs[i].exp_err));
        end

        // Pause/resume: pause at q=6, hold 4 cycles, resume, then abort.
        cmd(START, 3'd4, 3'd1, 1'b1, 1'b0);
        expect_out("pr.start", 4, 1, 0, 0, 0);
        nop();
        nop();
        expect_out("pr.run", 6, 1, 0, 0, 0);
        cmd(PAUSE, 3'd0, 3'd0, 1'b0, 1'b0);
        expect_out("pr.pause", 6, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            nop();
            expect_out($sformatf("pr.hold%0d", k), 6, 1, 0, 0, 0);
        end
        cmd(PAUSE, 3'd0, 3'd0, 1'b0, 1'b0);
        expect_out("pr.pause_in_pause", 6, 1, 0, 0, 1);
        cmd(RESUME, 3'd0, 3'd0, 1'b0, 1'b0);
        expect_out("pr.resume", 6, 1, 0, 0, 0);
        nop();
        expect_out("pr.after_resume", 7, 1, 0, 0, 0);
        cmd(ABORT, 3'd0, 3'd0, 1'b0, 1'b0);
        expect_out("pr.abort", 7, 0, 0, 0, 0);
        nop();
        expect_out("pr.idle", 7, 0, 0, 0, 0);

        // START on the edge where q == term: step suppressed, new run loaded.
        cmd(START, 3'd0, 3'd2, 1'b1, 1'b0);
        nop();
        nop();
        expect_out("col.at_term", 2, 1, 0, 0, 0);
        cmd(START, 3'd6, 3'd7, 1'b1, 1'b0);
        expect_out("col.restart", 6, 1, 0, 0, 0);
        cmd(RESUME, 3'd0, 3'd0, 1'b0, 1'b0);
        expect_out("col.resume_in_run", 6, 1, 0, 0, 1);
        nop();
        expect_out("col.step", 7, 1, 0, 0, 0);
        nop();
        expect_out("col.finish", 7, 0, 1, 1, 0);

        // init == term: one cycle showing init, then tc + done.
        cmd(START, 3'd3, 3'd3, 1'b0, 1'b0);
        expect_out("eq.start", 3, 1, 0, 0, 0);
        nop();
        expect_out("eq.term", 3, 0, 1, 1, 0);

        // Mid-run reset at q=4, with a command also presented.
        cmd(START, 3'd2, 3'd6, 1'b1, 1'b0);
        nop();
        nop();
        expect_out("mrst.run", 4, 1, 0, 0, 0);
        drive(1'b1, 1'b1, START, 3'd5, 3'd5, 1'b1, 1'b1);
        #1;
        chk("mrst.cmd_ready", int'(cmd_ready), 0);
        tick();
        expect_out("mrst.reset", 0, 0, 0, 0, 0);
        nop();
        chk("mrst.cmd_ready_after", int'(cmd_ready), 1);
        expect_out("mrst.idle", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
